// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default geometry and
// the address-width helper used to size the register index.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int AW_DEF = addr_width(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_read_port.sv
// One combinational read port: same-cycle write bypass with highest-port
// priority, register-0 masking, and the busy status seen by issue logic.
module rf_read_port #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     rf_data,
  input  logic                rf_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]     rd_data,
  output logic                rd_busy
);

  logic            hit;
  logic [XLEN-1:0] byp_data;

  always_comb begin
    hit      = 1'b0;
    byp_data = '0;
    // NOTE: blocking assignments let a later (higher-index) matching port
    // overwrite an earlier one within the same evaluation, giving priority.
    for (int j = 0; j < NWR; j++) begin
      if (BYPASS != 0 && wr_en[j] && wr_addr[j*AW +: AW] == rd_addr) begin
        hit      = 1'b1;
        byp_data = wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = rf_data;
    rd_busy = rf_busy;
    if (ZERO_REG != 0 && rd_addr == '0) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (hit) begin
      // The producer is writing back right now, so the operand is ready.
      rd_data = byp_data;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard,
// sitting between decode/issue (reads, busy checks) and writeback (writes).
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                areset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_set_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NWR-1:0]   wr_en_live;

  // Writes are dead while reset is held, including their bypass path.
  assign wr_en_live = wr_en & {NWR{areset}};

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      // NOTE: this array is reset on purpose: cleared registers are
      // architecturally visible here, unlike an ordinary storage RAM.
      for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0))
          rf_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    // NOTE: busy_d gets a full default before any conditional update, so no
    // path leaves it unassigned and no latch is inferred.
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
    end
    // A set after the clears: a newly issued producer outranks the retiring one.
    if (sb_set) busy_d[sb_set_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[i*AW +: AW];

    rf_read_port #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .rd_addr (addr),
      .rf_data (rf_q[addr]),
      .rf_busy (busy_q[addr]),
      .wr_en   (wr_en_live),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[i*XLEN +: XLEN]),
      .rd_busy (rd_busy[i])
    );
  end

endmodule
